// File: rtl/conv_out_collector_if.sv
// Handshake and data bundle between the PE channels, partial-sum FIFO,
// output FIFO and the conv_out_collector. master = environment, slave = collector.
interface conv_out_collector_if #(
    parameter int NUM_CH     = 4,
    parameter int PSUM_WIDTH = 16,
    parameter int OUT_WIDTH  = 17
);
    logic                         clear;
    logic [1:0]                   mode;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH*PSUM_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_ready;
    logic [PSUM_WIDTH-1:0]        psum_data;
    logic                         psum_empty;
    logic                         psum_ren;
    logic                         out_full;
    logic                         out_wen;
    logic [OUT_WIDTH-1:0]         out_din;
    logic                         busy;
    logic [15:0]                  wr_count;
    logic                         sat_flag;

    modport master (
        output clear, mode, ch_valid, ch_data, psum_data, psum_empty, out_full,
        input  ch_ready, psum_ren, out_wen, out_din, busy, wr_count, sat_flag
    );

    modport slave (
        input  clear, mode, ch_valid, ch_data, psum_data, psum_empty, out_full,
        output ch_ready, psum_ren, out_wen, out_din, busy, wr_count, sat_flag
    );
endinterface

// File: rtl/conv_out_collector.sv
// Multi-channel PE result collector: PASS / ACC / REDUCE into one output FIFO.
// Optional OUT_SAT_EN: saturating narrowing to OUT_WIDTH with sticky sat_flag.
module conv_out_collector #(
    parameter int NUM_CH     = 4,
    parameter int PSUM_WIDTH = 16,
    parameter int OUT_WIDTH  = 17
) (
    input  logic                   clk,
    input  logic                   rstn,
    conv_out_collector_if.slave    bus
);
    localparam int GW    = $clog2(NUM_CH);
    localparam int SUM_W = PSUM_WIDTH + $clog2(NUM_CH) + 1;
    localparam int EXT_W = (SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH;
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_CH - 1);
    localparam logic [1:0] MODE_ACC    = 2'b01;
    localparam logic [1:0] MODE_REDUCE = 2'b10;

    typedef enum logic {PICK = 1'b0, WRITE = 1'b1} state_e;

    state_e                       state_q, state_d;
    logic [NUM_CH-1:0]            hold_vld_q, hold_vld_d;
    logic signed [PSUM_WIDTH-1:0] hold_dat_q [NUM_CH];
    logic [GW-1:0]                last_gnt_q, last_gnt_d;
    logic [OUT_WIDTH-1:0]         out_din_q, out_din_d;
    logic [15:0]                  wr_count_q, wr_count_d;

    logic [NUM_CH-1:0]            ch_ready, capture;
    logic [GW-1:0]                gnt_idx, cand;
    logic                         gnt_found, pick_fire, clamp;
    logic signed [EXT_W-1:0]      pass_sum, acc_sum, red_sum, sel_sum;
    logic [OUT_WIDTH-1:0]         narrow_out;

    function automatic logic signed [EXT_W-1:0] sext(input logic [PSUM_WIDTH-1:0] v);
        return {{(EXT_W-PSUM_WIDTH){v[PSUM_WIDTH-1]}}, v};
    endfunction

    assign ch_ready     = {NUM_CH{rstn & ~bus.clear}} & ~hold_vld_q;
    assign capture      = bus.ch_valid & ch_ready;
    assign bus.ch_ready = ch_ready;
    assign bus.out_din  = out_din_q;
    assign bus.wr_count = wr_count_q;
    assign bus.busy     = (|hold_vld_q) | (state_q == WRITE);

    // Round-robin search from last_gnt+1; descending k lets the nearest hit win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = GW'((int'(last_gnt_q) + k) % NUM_CH);
            if (hold_vld_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        pass_sum = sext(hold_dat_q[gnt_idx]);
        acc_sum  = pass_sum + sext(bus.psum_data);
        red_sum  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            red_sum = red_sum + sext(hold_dat_q[i]);
        end
        case (bus.mode)
            MODE_ACC:    sel_sum = acc_sum;
            MODE_REDUCE: sel_sum = red_sum;
            default:     sel_sum = pass_sum;
        endcase
    end

`ifdef OUT_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
    logic sat_q, sat_d;

    always_comb begin
        narrow_out = sel_sum[OUT_WIDTH-1:0];
        clamp      = 1'b0;
        if (sel_sum > SAT_MAX) begin
            narrow_out = SAT_MAX[OUT_WIDTH-1:0];
            clamp      = 1'b1;
        end else if (sel_sum < SAT_MIN) begin
            narrow_out = SAT_MIN[OUT_WIDTH-1:0];
            clamp      = 1'b1;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (bus.clear)
            sat_d = 1'b0;
        else if (pick_fire && clamp)
            sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign bus.sat_flag = sat_q;
`else
    logic unused_sum;

    assign narrow_out   = sel_sum[OUT_WIDTH-1:0];
    assign clamp        = 1'b0;
    assign unused_sum   = ^{sel_sum, clamp};
    assign bus.sat_flag = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        hold_vld_d   = hold_vld_q | capture;
        last_gnt_d   = last_gnt_q;
        out_din_d    = out_din_q;
        wr_count_d   = wr_count_q;
        pick_fire    = 1'b0;
        bus.psum_ren = 1'b0;
        bus.out_wen  = 1'b0;
        if (bus.clear) begin
            state_d    = PICK;
            hold_vld_d = '0;
            last_gnt_d = LAST_INIT;
            out_din_d  = '0;
            wr_count_d = '0;
        end else begin
            case (state_q)
                PICK: begin
                    case (bus.mode)
                        MODE_ACC:    pick_fire = gnt_found & ~bus.psum_empty;
                        MODE_REDUCE: pick_fire = &hold_vld_q;
                        default:     pick_fire = gnt_found;
                    endcase
                    bus.psum_ren = pick_fire & (bus.mode == MODE_ACC);
                    if (pick_fire) begin
                        out_din_d = narrow_out;
                        state_d   = WRITE;
                        if (bus.mode == MODE_REDUCE) begin
                            hold_vld_d = '0;
                        end else begin
                            hold_vld_d[gnt_idx] = 1'b0;
                            last_gnt_d          = gnt_idx;
                        end
                    end
                end
                WRITE: begin
                    bus.out_wen = ~bus.out_full;
                    if (!bus.out_full) begin
                        wr_count_d = wr_count_q + 16'd1;
                        state_d    = PICK;
                    end
                end
                default: state_d = PICK;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the combinational blocks above use blocking ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= PICK;
            hold_vld_q <= '0;
            last_gnt_q <= LAST_INIT;
            out_din_q  <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            last_gnt_q <= last_gnt_d;
            out_din_q  <= out_din_d;
            wr_count_q <= wr_count_d;
        end
    end

    // NOTE: hold data needs no reset; it is only consumed while hold_vld is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture[i]) hold_dat_q[i] <= bus.ch_data[i*PSUM_WIDTH +: PSUM_WIDTH];
        end
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector (NUM_CH=4, PSUM_WIDTH=16, OUT_WIDTH=16).
// Expectations follow OUT_SAT_EN when it is defined for the build.
module tb_conv_out_collector;
    localparam int NUM_CH = 4;
    localparam int PW     = 16;
    localparam int OW     = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    conv_out_collector_if #(.NUM_CH(NUM_CH), .PSUM_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

    conv_out_collector #(.NUM_CH(NUM_CH), .PSUM_WIDTH(PW), .OUT_WIDTH(OW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.clear = 1'b0; bus.mode = 2'b00; bus.ch_valid = '0; bus.ch_data = '0;
        bus.psum_data = '0; bus.psum_empty = 1'b1; bus.out_full = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        if (bus.ch_ready !== 4'h0) begin $display("FAIL reset_ready_low: got %h want 0", bus.ch_ready); tests_failed++; end
        tests_run++;
        rstn = 1'b1;
        #1;
        if (bus.ch_ready !== 4'hF) begin $display("FAIL reset_ready: got %h want f", bus.ch_ready); tests_failed++; end
        tests_run++;
        if ({bus.psum_ren, bus.out_wen, bus.busy, bus.sat_flag} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", {bus.psum_ren, bus.out_wen, bus.busy, bus.sat_flag}); tests_failed++;
        end
        tests_run++;
        if (bus.out_din !== 16'h0 || bus.wr_count !== 16'h0) begin
            $display("FAIL reset_data: got din %h cnt %0d want 0 0", bus.out_din, bus.wr_count); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_pass();
        bus.mode     = 2'b00;
        bus.ch_data  = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.ch_valid = 4'hF;
        tick();
        bus.ch_valid = '0;
        if (bus.ch_ready !== 4'h0 || bus.out_wen !== 1'b0) begin
            $display("FAIL pass_capture: got ready %h wen %b want 0 0", bus.ch_ready, bus.out_wen); tests_failed++;
        end
        tests_run++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.out_wen !== 1'b1 || bus.out_din !== 16'(k + 1)) begin
                $display("FAIL pass_out%0d: got wen %b din %h want 1 %h", k, bus.out_wen, bus.out_din, 16'(k + 1)); tests_failed++;
            end
            tests_run++;
            if (k == 0) begin
                if (bus.ch_ready !== 4'b0001) begin $display("FAIL pass_refill: got %b want 0001", bus.ch_ready); tests_failed++; end
                tests_run++;
            end
            tick();
            if (bus.out_wen !== 1'b0) begin $display("FAIL pass_gap%0d: got wen %b want 0", k, bus.out_wen); tests_failed++; end
            tests_run++;
        end
        if (bus.wr_count !== 16'd4 || bus.busy !== 1'b0) begin
            $display("FAIL pass_count: got cnt %0d busy %b want 4 0", bus.wr_count, bus.busy); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_acc();
        int pops = 0;
        bus.mode       = 2'b01;
        bus.psum_empty = 1'b1;
        bus.psum_data  = 16'd12;
        bus.ch_data    = {16'd0, 16'd0, 16'hFFFB, 16'd0};
        bus.ch_valid   = 4'b0010;
        tick();
        bus.ch_valid = '0;
        for (int c = 0; c < 10; c++) begin
            if (bus.psum_ren !== 1'b0 || bus.out_wen !== 1'b0) pops++;
            tick();
        end
        if (pops !== 0) begin $display("FAIL acc_stall: got %0d active cycles want 0", pops); tests_failed++; end
        tests_run++;
        if (bus.ch_ready[1] !== 1'b0) begin $display("FAIL acc_stall_ready: got %b want 0", bus.ch_ready[1]); tests_failed++; end
        tests_run++;
        bus.psum_empty = 1'b0;
        #1;
        if (bus.psum_ren !== 1'b1) begin $display("FAIL acc_pop: got %b want 1", bus.psum_ren); tests_failed++; end
        tests_run++;
        tick();
        bus.psum_empty = 1'b1;
        if (bus.psum_ren !== 1'b0 || bus.out_wen !== 1'b1 || bus.out_din !== 16'd7) begin
            $display("FAIL acc_out: got ren %b wen %b din %h want 0 1 0007", bus.psum_ren, bus.out_wen, bus.out_din); tests_failed++;
        end
        tests_run++;
        tick();
        if (bus.wr_count !== 16'd5 || bus.out_wen !== 1'b0) begin
            $display("FAIL acc_count: got cnt %0d wen %b want 5 0", bus.wr_count, bus.out_wen); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_reduce();
        int early = 0;
        bus.mode     = 2'b10;
        bus.ch_data  = {16'd400, 16'd300, 16'd200, 16'd100};
        bus.ch_valid = 4'b0111;
        tick();
        bus.ch_valid = '0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_wen !== 1'b0) early++;
            tick();
        end
        if (early !== 0 || bus.busy !== 1'b1) begin
            $display("FAIL reduce_wait: got writes %0d busy %b want 0 1", early, bus.busy); tests_failed++;
        end
        tests_run++;
        bus.ch_valid = 4'b1000;
        tick();
        bus.ch_valid = '0;
        if (bus.out_wen !== 1'b0) begin $display("FAIL reduce_n: got wen %b want 0", bus.out_wen); tests_failed++; end
        tests_run++;
        tick();
        if (bus.out_wen !== 1'b1 || bus.out_din !== 16'd1000) begin
            $display("FAIL reduce_out: got wen %b din %0d want 1 1000", bus.out_wen, bus.out_din); tests_failed++;
        end
        tests_run++;
        tick();
        tick();
        if (bus.out_wen !== 1'b0 || bus.wr_count !== 16'd6 || bus.ch_ready !== 4'hF) begin
            $display("FAIL reduce_once: got wen %b cnt %0d ready %h want 0 6 f", bus.out_wen, bus.wr_count, bus.ch_ready); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.mode     = 2'b00;
        bus.out_full = 1'b1;
        bus.ch_data  = {16'd0, 16'h1234, 16'd0, 16'd0};
        bus.ch_valid = 4'b0100;
        tick();
        bus.ch_valid = '0;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (bus.out_wen !== 1'b0 || bus.out_din !== 16'h1234) bad++;
            tick();
        end
        if (bad !== 0) begin $display("FAIL full_hold: got %0d bad cycles want 0", bad); tests_failed++; end
        tests_run++;
        bus.out_full = 1'b0;
        #1;
        if (bus.out_wen !== 1'b1 || bus.out_din !== 16'h1234) begin
            $display("FAIL full_release: got wen %b din %h want 1 1234", bus.out_wen, bus.out_din); tests_failed++;
        end
        tests_run++;
        tick();
        if (bus.out_wen !== 1'b0 || bus.wr_count !== 16'd7) begin
            $display("FAIL full_count: got wen %b cnt %0d want 0 7", bus.out_wen, bus.wr_count); tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_saturation();
        logic [15:0] exp_din;
        logic        exp_sat;
`ifdef OUT_SAT_EN
        exp_din = 16'h7FFF; exp_sat = 1'b1;
`else
        exp_din = 16'hFFFC; exp_sat = 1'b0;
`endif
        bus.mode     = 2'b10;
        bus.ch_data  = {4{16'h7FFF}};
        bus.ch_valid = 4'hF;
        tick();
        bus.ch_valid = '0;
        tick();
        if (bus.out_wen !== 1'b1 || bus.out_din !== exp_din) begin
            $display("FAIL sat_out: got wen %b din %h want 1 %h", bus.out_wen, bus.out_din, exp_din); tests_failed++;
        end
        tests_run++;
        if (bus.sat_flag !== exp_sat) begin $display("FAIL sat_flag: got %b want %b", bus.sat_flag, exp_sat); tests_failed++; end
        tests_run++;
        tick();
        if (bus.wr_count !== 16'd8) begin $display("FAIL sat_count: got %0d want 8", bus.wr_count); tests_failed++; end
        tests_run++;
    endtask

    task automatic test_reset_clear();
        bus.mode     = 2'b00;
        bus.out_full = 1'b1;
        bus.ch_data  = {16'd0, 16'd0, 16'h0055, 16'd0};
        bus.ch_valid = 4'b0010;
        tick();
        bus.ch_valid = '0;
        tick();
        bus.out_full = 1'b0;
        #1;
        if (bus.out_wen !== 1'b1) begin $display("FAIL rst_pre: got wen %b want 1", bus.out_wen); tests_failed++; end
        tests_run++;
        rstn = 1'b0;
        #1;
        if ({bus.out_wen, bus.psum_ren, bus.busy, bus.sat_flag} !== 4'b0000 || bus.ch_ready !== 4'h0) begin
            $display("FAIL rst_async: got flags %b ready %h want 0000 0", {bus.out_wen, bus.psum_ren, bus.busy, bus.sat_flag}, bus.ch_ready); tests_failed++;
        end
        tests_run++;
        if (bus.out_din !== 16'h0 || bus.wr_count !== 16'h0) begin
            $display("FAIL rst_data: got din %h cnt %0d want 0 0", bus.out_din, bus.wr_count); tests_failed++;
        end
        tests_run++;
        tick();
        rstn = 1'b1;
        // Stream ch1, ch2; clear lands while ch2 is waiting in WRITE.
        bus.ch_data  = {16'd0, 16'h0022, 16'h0011, 16'd0};
        bus.ch_valid = 4'b0110;
        tick();
        bus.ch_valid = '0;
        tick(); tick(); tick();
        if (bus.out_wen !== 1'b1 || bus.out_din !== 16'h0022 || bus.wr_count !== 16'd1) begin
            $display("FAIL clr_pre: got wen %b din %h cnt %0d want 1 0022 1", bus.out_wen, bus.out_din, bus.wr_count); tests_failed++;
        end
        tests_run++;
        bus.clear = 1'b1;
        #1;
        if (bus.out_wen !== 1'b0 || bus.ch_ready !== 4'h0) begin
            $display("FAIL clr_drop: got wen %b ready %h want 0 0", bus.out_wen, bus.ch_ready); tests_failed++;
        end
        tests_run++;
        tick();
        bus.clear = 1'b0;
        #1;
        if (bus.wr_count !== 16'd0 || bus.busy !== 1'b0 || bus.out_din !== 16'h0 || bus.ch_ready !== 4'hF || bus.out_wen !== 1'b0) begin
            $display("FAIL clr_state: got cnt %0d busy %b din %h ready %h wen %b want 0 0 0 f 0",
                     bus.wr_count, bus.busy, bus.out_din, bus.ch_ready, bus.out_wen); tests_failed++;
        end
        tests_run++;
        bus.ch_data  = {16'h00D3, 16'd0, 16'd0, 16'h00A0};
        bus.ch_valid = 4'b1001;
        tick();
        bus.ch_valid = '0;
        tick();
        if (bus.out_wen !== 1'b1 || bus.out_din !== 16'h00A0) begin
            $display("FAIL clr_grant0: got wen %b din %h want 1 00a0", bus.out_wen, bus.out_din); tests_failed++;
        end
        tests_run++;
        tick();
        tick();
        if (bus.out_din !== 16'h00D3 || bus.wr_count !== 16'd1) begin
            $display("FAIL clr_next: got din %h cnt %0d want 00d3 1", bus.out_din, bus.wr_count); tests_failed++;
        end
        tests_run++;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_acc();
        test_reduce();
        test_backpressure();
        test_saturation();
        test_reset_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
